// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM latch and a word-mode data_memory.
// Handles byte-lane extraction, sign/zero extension, sub-word read-modify-write and error flagging.
module load_store_unit #(
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [1:0]             i_req_size,
    input  logic                   i_req_unsigned,
    input  logic [ADDR_LENGTH-1:0] i_req_addr,
    input  logic [DATA_LENGTH-1:0] i_req_wdata,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    output logic [4:0]             o_mem_size_control,
    output logic [DATA_LENGTH-1:0] o_mem_wdata,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DATA_LENGTH-1:0] o_rsp_rdata,
    output logic                   o_rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    logic [1:0]             state_q, state_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] wdata_q, wdata_d;
    logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [ADDR_LENGTH-1:0] req_word_idx;
    logic                   req_err;
    logic [4:0]             byte_shift;
    logic [4:0]             half_shift;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [DATA_LENGTH-1:0] load_ext;
    logic [DATA_LENGTH-1:0] merged;

    assign req_word_idx = i_req_addr >> 2;
    assign req_err = (i_req_size == 2'b00)
                  || (i_req_size == SZ_HALF && i_req_addr[0])
                  || (i_req_size == SZ_WORD && i_req_addr[1:0] != 2'b00)
                  || (req_word_idx >= ADDR_LENGTH'(MEM_SIZE));

    // Lane positions come from the latched address, so they are stable through RD.
    assign byte_shift = {addr_q[1:0], 3'b000};
    assign half_shift = {addr_q[1], 4'b0000};
    assign rd_byte    = 8'(i_mem_rdata >> byte_shift);
    assign rd_half    = 16'(i_mem_rdata >> half_shift);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        load_ext = i_mem_rdata;
        merged   = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                load_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                merged   = (i_mem_rdata & ~(32'h0000_00FF << byte_shift))
                         | ({24'b0, wdata_q[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                merged   = (i_mem_rdata & ~(32'h0000_FFFF << half_shift))
                         | ({16'b0, wdata_q[15:0]} << half_shift);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)                                state_d = S_RSP;
                    else if (!i_req_we || i_req_size != SZ_WORD) state_d = S_RD;
                    else                                        state_d = S_WR;
                end
            end
            S_RD: begin
                if (!we_q) begin
                    rdata_d = load_ext;
                    state_d = S_RSP;
                end else begin
                    wdata_d = merged;
                    state_d = S_WR;
                end
            end
            S_WR:    state_d = S_RSP;
            default: if (i_rsp_ready) state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked by reset so it reads 0 while reset is held.
    assign o_req_ready        = i_rst && (state_q == S_IDLE);
    assign o_mem_re           = (state_q == S_RD);
    assign o_mem_we           = (state_q == S_WR);
    assign o_mem_size_control = 5'b00000;
    assign o_mem_addr         = addr_q >> 2;
    assign o_mem_wdata        = wdata_q;
    assign o_rsp_valid        = (state_q == S_RSP);
    assign o_rsp_rdata        = rdata_q;
    assign o_rsp_err          = err_q;

endmodule
